// File: rtl/ff_queue_pkg.sv
// Shared constants, pointer/count typedefs and pointer-wrap helper for ff_queue_1r_1w.
package ff_queue_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;
    localparam int DEFAULT_PTR_WIDTH  = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_PTR_WIDTH-1:0] ptr_t;
    typedef logic [DEFAULT_PTR_WIDTH:0]   cnt_t;

    // Depth is a power of two, so masking is the same as the natural pointer overflow.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1) & (depth - 1);
    endfunction

endpackage

// File: rtl/ff_queue_entry.sv
// One payload slot of ff_queue_1r_1w: a DATA_WIDTH flop with write enable.
module ff_queue_entry
    import ff_queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (wr_en) begin
            data <= wr_data;
        end
    end

endmodule

// File: rtl/ff_queue_1r_1w.sv
// Circular flop queue with valid/ready push and pop, combinational head read.
// Optional zero-latency fall-through when empty: define FF_QUEUE_BYPASS_EN.
module ff_queue_1r_1w
    import ff_queue_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  DEPTH      = DEFAULT_DEPTH,
    localparam int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic [PTR_WIDTH:0]    count_o,
    input  logic                  flush_i
);

    localparam int                   CNT_WIDTH  = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("ff_queue_1r_1w: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_WIDTH-1:0]  head_q;
    logic [PTR_WIDTH-1:0]  tail_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [DATA_WIDTH-1:0] entry_q [DEPTH];
    logic                  stored_valid;
    logic                  bypass_take;
    logic                  push_fire;
    logic                  pop_fire;

    assign stored_valid = (count_q != '0);
    assign push_ready_o = (count_q != FULL_COUNT);
    assign count_o      = count_q;

`ifdef FF_QUEUE_BYPASS_EN
    logic bypass;

    // An empty queue presents the incoming item directly; if taken, it never lands in storage.
    assign bypass      = !stored_valid && push_valid_i;
    assign bypass_take = bypass && pop_ready_i;
    assign pop_valid_o = stored_valid || bypass;
    assign pop_data_o  = bypass       ? push_data_i :
                         stored_valid ? entry_q[head_q] : '0;
`else
    assign bypass_take = 1'b0;
    assign pop_valid_o = stored_valid;
    assign pop_data_o  = stored_valid ? entry_q[head_q] : '0;
`endif

    assign push_fire = push_valid_i && push_ready_o && !flush_i && !bypass_take;
    assign pop_fire  = stored_valid && pop_ready_i && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_fire) begin
                tail_q <= PTR_WIDTH'(next_ptr(32'(tail_q), DEPTH));
            end
            if (pop_fire) begin
                head_q <= PTR_WIDTH'(next_ptr(32'(head_q), DEPTH));
            end
            case ({push_fire, pop_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        ff_queue_entry #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_entry (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_en  (push_fire && (tail_q == PTR_WIDTH'(i))),
            .wr_data(push_data_i),
            .data   (entry_q[i])
        );
    end

endmodule

// File: tb/tb_ff_queue_1r_1w.sv
// Directed-vector bench for ff_queue_1r_1w (DATA_WIDTH=32, DEPTH=4).
module tb_ff_queue_1r_1w;

    logic        clk;
    logic        rst_n;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_data;
    logic        pop_valid;
    logic        pop_ready;
    logic [31:0] pop_data;
    logic [2:0]  count;
    logic        flush;

    int vectors;
    int miscompares;

    ff_queue_1r_1w #(
        .DATA_WIDTH(32),
        .DEPTH     (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_valid_i(push_valid),
        .push_ready_o(push_ready),
        .push_data_i (push_data),
        .pop_valid_o (pop_valid),
        .pop_ready_i (pop_ready),
        .pop_data_o  (pop_data),
        .count_o     (count),
        .flush_i     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

    task automatic drive(input logic pv, input logic [31:0] pd, input logic pr, input logic fl);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        flush      = fl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (pop_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_pop_valid cycle %0d: got %b want 0", c, pop_valid);
            end
            vectors++;
            if (pop_data !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_pop_data cycle %0d: got %h want 0", c, pop_data);
            end
            vectors++;
            if (push_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_push_ready cycle %0d: got %b want 1", c, push_ready);
            end
            vectors++;
            if (count !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_count cycle %0d: got %0d want 0", c, count);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] pat [4];
        pat[0] = 32'hA1; pat[1] = 32'hB2; pat[2] = 32'hC3; pat[3] = 32'hD4;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pat[i], 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 32'hEE, 1'b0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd4) begin
            miscompares++;
            $display("FAIL fill_count: got %0d want 4", count);
        end
        vectors++;
        if (push_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_push_ready: got %b want 0", push_ready);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd4) begin
            miscompares++;
            $display("FAIL fifth_push_count: got %0d want 4", count);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            vectors++;
            if (pop_data !== pat[i]) begin
                miscompares++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, pop_data, pat[i]);
            end
            vectors++;
            if (count !== 3'(4 - i)) begin
                miscompares++;
                $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 4 - i);
            end
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (pop_valid !== 1'b0 || pop_data !== 32'h0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL drained_empty: got valid=%b data=%h count=%0d want 0/0/0",
                     pop_valid, pop_data, count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] pat [4];
        logic [31:0] rest [3];
        pat[0] = 32'hA1; pat[1] = 32'hB2; pat[2] = 32'hC3; pat[3] = 32'hD4;
        rest[0] = 32'hB2; rest[1] = 32'hC3; rest[2] = 32'hD4;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pat[i], 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 32'h55, 1'b1, 1'b0);
        #1;
        vectors++;
        if (pop_data !== 32'hA1) begin
            miscompares++;
            $display("FAIL full_pushpop_head: got %h want a1", pop_data);
        end
        vectors++;
        if (push_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pushpop_ready: got %b want 0", push_ready);
        end
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            if (j == 0) begin
                vectors++;
                if (count !== 3'd3) begin
                    miscompares++;
                    $display("FAIL full_pushpop_count: got %0d want 3", count);
                end
            end
            vectors++;
            if (pop_data !== rest[j]) begin
                miscompares++;
                $display("FAIL full_pushpop_drain[%0d]: got %h want %h", j, pop_data, rest[j]);
            end
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd0 || pop_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pushpop_55_absent: got count=%0d valid=%b want 0/0", count, pop_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h01, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 1; k < 10; k++) begin
            drive(1'b1, 32'(k + 1), 1'b1, 1'b0);
            #1;
            vectors++;
            if (pop_data !== 32'(k)) begin
                miscompares++;
                $display("FAIL b2b_data[%0d]: got %h want %h", k, pop_data, 32'(k));
            end
            vectors++;
            if (count !== 3'd1) begin
                miscompares++;
                $display("FAIL b2b_count[%0d]: got %0d want 1", k, count);
            end
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (pop_data !== 32'h0A || count !== 3'd1) begin
            miscompares++;
            $display("FAIL b2b_last: got data=%h count=%0d want 0a/1", pop_data, count);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL b2b_empty: got %0d want 0", count);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h77, 1'b0, 1'b1);
        #1;
        vectors++;
        if (count !== 3'd2) begin
            miscompares++;
            $display("FAIL flush_pre_count: got %0d want 2", count);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd0 || pop_valid !== 1'b0 || pop_data !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_cleared: got count=%0d valid=%b data=%h want 0/0/0",
                     count, pop_valid, pop_data);
        end
        @(negedge clk);
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd1 || pop_data !== 32'h33) begin
            miscompares++;
            $display("FAIL flush_after_push: got count=%0d data=%h want 1/33", count, pop_data);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_77_absent: got count=%0d want 0", count);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h61, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h62, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h63, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h64, 1'b1, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL areset_pre_count: got %0d want 3", count);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (count !== 3'd0 || pop_valid !== 1'b0 || pop_data !== 32'h0 || push_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_immediate: got count=%0d valid=%b data=%h ready=%b want 0/0/0/1",
                     count, pop_valid, pop_data, push_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd0 || pop_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_release: got count=%0d valid=%b want 0/0", count, pop_valid);
        end
        @(negedge clk);
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (pop_data !== 32'h99 || count !== 3'd1 || pop_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_first_push: got data=%h count=%0d valid=%b want 99/1/1",
                     pop_data, count, pop_valid);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL areset_drain: got %0d want 0", count);
        end
    endtask

`ifdef FF_QUEUE_BYPASS_EN
    task automatic test_bypass();
        drive(1'b1, 32'h42, 1'b1, 1'b0);
        #1;
        vectors++;
        if (pop_valid !== 1'b1 || pop_data !== 32'h42) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got valid=%b data=%h want 1/42", pop_valid, pop_data);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd0 || pop_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_not_stored: got count=%0d valid=%b want 0/0", count, pop_valid);
        end
        drive(1'b1, 32'h43, 1'b0, 1'b0);
        #1;
        vectors++;
        if (pop_valid !== 1'b1 || pop_data !== 32'h43) begin
            miscompares++;
            $display("FAIL bypass_stall_view: got valid=%b data=%h want 1/43", pop_valid, pop_data);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd1 || pop_data !== 32'h43) begin
            miscompares++;
            $display("FAIL bypass_stall_stored: got count=%0d data=%h want 1/43", count, pop_data);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask
`else
    task automatic test_no_bypass();
        drive(1'b1, 32'h44, 1'b1, 1'b0);
        #1;
        vectors++;
        if (pop_valid !== 1'b0 || pop_data !== 32'h0) begin
            miscompares++;
            $display("FAIL empty_pushpop_no_fallthrough: got valid=%b data=%h want 0/0", pop_valid, pop_data);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd1 || pop_data !== 32'h44) begin
            miscompares++;
            $display("FAIL empty_pushpop_stored: got count=%0d data=%h want 1/44", count, pop_data);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL empty_pushpop_drain: got %0d want 0", count);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef FF_QUEUE_BYPASS_EN
        test_bypass();
`else
        test_no_bypass();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ff_queue_1r_1w.md
Name: ff_queue_1r_1w

Overview:
- Circular queue of DATA_WIDTH-bit flop entries.
  - Producer side: valid/ready push.
  - Consumer side: valid/ready pop.
- Read data is combinational from the head entry.
- Sits between OoO pipeline stages (e.g. dispatch -> issue, or execute -> commit) where a single flop slot is too shallow and back-pressure is required.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 4, number of entries; power of two, >= 2.
- PTR_WIDTH, $clog2(DEPTH), head/tail pointer width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- push_valid_i  input  1  producer has data.
- push_ready_o  output  1  queue can accept (not full).
- push_data_i  input  DATA_WIDTH  producer payload.
- pop_valid_o  output  1  head entry holds valid data (not empty).
- pop_ready_i  input  1  consumer takes head this cycle.
- pop_data_o  output  DATA_WIDTH  head payload; all-zero when pop_valid_o=0.
- count_o  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- flush_i  input  1  synchronous clear (pipeline squash).

Behaviour:
- Reset (rst_n low, async):
  - head = tail = 0, count_o = 0, all entries cleared to 0.
  - push_ready_o = 1, pop_valid_o = 0, pop_data_o = 0.
- Push fires when push_valid_i & push_ready_o: entry[tail] <= push_data_i, tail increments.
- Pop fires when pop_valid_o & pop_ready_i: head increments. Entry content is not cleared on pop.
- Pointers wrap modulo DEPTH, implicit via PTR_WIDTH overflow.
- Count tracks separately, so full and empty are distinguishable when head == tail.
- count_o update: +1 on push only, -1 on pop only, unchanged on both or neither.
- push_ready_o = (count_o != DEPTH). Purely registered-state derived; no combinational path from pop_ready_i.
- pop_valid_o = (count_o != 0).
- pop_data_o = entry[head] when pop_valid_o, else 0. Combinational read, zero latency.
- Push-to-pop latency: 1 cycle (data written at edge N is visible at pop_data_o after edge N).
- Full + simultaneous push and pop: push is refused (push_ready_o = 0); the pop proceeds; count goes DEPTH -> DEPTH-1.
- Empty + simultaneous push and pop: the pop does not fire; the push proceeds; count goes 0 -> 1.
- flush_i = 1 at a clock edge:
  - head = tail = 0, count = 0.
  - Any concurrent push or pop is discarded.
  - Entry contents are left unchanged.
- rst_n asserted mid-transfer: the operation is dropped and state returns to reset values immediately. No partial writes are visible after deassertion.
- Illegal DEPTH (not a power of two, or < 2): elaboration-time error via generate check.

Optional Feature:
- Macro: FF_QUEUE_BYPASS_EN.
- Defined:
  - When count_o == 0 and push_valid_i = 1, pop_valid_o = 1 and pop_data_o = push_data_i in the same cycle (zero-latency fall-through).
  - If pop_ready_i is also 1, the item is consumed without being written: pointers and count are unchanged.
  - Otherwise the item is written normally.
- Undefined:
  - Strictly 1-cycle latency as above.
  - No combinational path from push_* to pop_*.

Decomposition:
- Package ff_queue_pkg holds:
  - Default width constants.
  - ptr_t / cnt_t typedef helpers.
  - A function for next-pointer wrap.
- Sub-module: ff_queue_entry.
  - Single DATA_WIDTH flop with write enable and async active-low reset.
  - Instantiated DEPTH times via generate.
  - The read mux lives in the top module.

Test Plan:
- Reset then idle: pop_valid_o=0, pop_data_o=0, push_ready_o=1, count_o=0 held for 5 cycles.
- Push 0xA1,0xB2,0xC3,0xD4 back-to-back (DEPTH=4), pop_ready_i=0 -> count_o=4, push_ready_o=0; a 5th push of 0xEE is ignored; popping 4 yields A1,B2,C3,D4 in order.
- Full, push 0x55 and pop same cycle -> 0xA1 popped, 0x55 not stored, count_o 4->3.
- Continuous push/pop for 10 items, 0x01..0x0A -> order preserved across pointer wrap, count_o stays at 1 steady-state.
- Two entries queued, assert flush_i with push_valid_i=1 (0x77) -> next cycle count_o=0, pop_valid_o=0, 0x77 absent.
- rst_n pulsed low mid-stream with 3 entries -> outputs go to reset values immediately (asynchronously); after release, the first push of 0x99 pops as 0x99. With FF_QUEUE_BYPASS_EN: empty, push 0x42 with pop_ready_i=1 -> pop_data_o=0x42 same cycle, count_o stays 0.
